// File: rtl/fdc_pkg.sv
// Shared types and defaults for the reference-frequency generator (NCO stimulus
// source for the FDC self-test path).
package fdc_pkg;

   localparam int unsigned ACC_W_DEF = 16;
   localparam int unsigned CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fdc_state_e;

   // Tuning word for a target f_out given f_clk: fword = f_out * 2^acc_w / f_clk.
   function automatic longint unsigned fword_for(input longint unsigned f_out_hz,
                                                 input longint unsigned f_clk_hz,
                                                 input int unsigned     acc_w);
      return (f_out_hz << acc_w) / f_clk_hz;
   endfunction

endpackage

// File: rtl/fdc_phase_acc.sv
// Phase accumulator with registered MSB output and falling-edge detect of that
// output, evaluated on the update that is about to happen.
module fdc_phase_acc #(
   parameter int unsigned ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             step,
   input  logic [ACC_W-1:0] fword,
   output logic             f_out,
   output logic             fall
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;

   always_comb begin
      acc_nxt = acc + fword;
      fall    = step & f_out & ~acc_nxt[ACC_W-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         f_out <= 1'b0;
      end else if (clear) begin
         acc   <= '0;
         f_out <= 1'b0;
      end else if (step) begin
         acc   <= acc_nxt;
         f_out <= acc_nxt[ACC_W-1];
      end
   end

endmodule

// File: rtl/fdc_ref_gen.sv
// Programmable square-wave generator: burst of N periods or continuous output,
// with run control, period counting and a one-cycle completion pulse.
module fdc_ref_gen
   import fdc_pkg::*;
#(
   parameter int unsigned ACC_W = ACC_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [ACC_W-1:0] freq_word,
   input  logic             load,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             start,
   input  logic             stop,
   output logic             f_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period_cnt
);

   fdc_state_e       state;
   logic [ACC_W-1:0] fword_r;
   logic [CNT_W-1:0] len_r;
   logic             clear;
   logic             step;
   logic             fall;
   logic             last_period;

   // Stop clears the phase in any state; start only clears it from IDLE.
   always_comb begin
      clear       = ena & (stop | ((state == IDLE) & start));
      step        = ena & ~stop & (state == RUN);
      last_period = (len_r != '0) &&
                    ((CNT_W+1)'(period_cnt) + (CNT_W+1)'(1) == (CNT_W+1)'(len_r));
   end

   fdc_phase_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .step  (step),
      .fword (fword_r),
      .f_out (f_out),
      .fall  (fall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         fword_r    <= '0;
         len_r      <= '0;
         period_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (ena) begin
         if (load)
            fword_r <= freq_word;
         done <= 1'b0;
         if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  len_r      <= burst_len;
                  period_cnt <= '0;
               end
               RUN: if (fall) begin
                  if (!(&period_cnt))
                     period_cnt <= period_cnt + 1'b1;
                  if (last_period) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fdc_ref_gen.sv
// Scoreboard bench for fdc_ref_gen: a behavioural model predicts outputs per
// cycle, and per-scenario tasks add targeted timing checks.
module tb_fdc_ref_gen;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ena = 1'b0;
   logic [15:0] freq_word = '0;
   logic        load = 1'b0;
   logic [7:0]  burst_len = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        f_out;
   logic        busy;
   logic        done;
   logic [7:0]  period_cnt;

   int unsigned errors = 0;
   int unsigned checks = 0;

   typedef struct packed {
      logic       f;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } exp_t;
   exp_t exp_q[$];

   // reference model state
   int          m_state;
   logic [15:0] m_acc;
   logic [15:0] m_fword;
   logic [7:0]  m_len;
   logic [7:0]  m_cnt;
   logic        m_f;

   fdc_ref_gen #(.ACC_W(16), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .freq_word  (freq_word),
      .load       (load),
      .burst_len  (burst_len),
      .start      (start),
      .stop       (stop),
      .f_out      (f_out),
      .busy       (busy),
      .done       (done),
      .period_cnt (period_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_acc = '0; m_fword = '0; m_len = '0; m_cnt = '0; m_f = 1'b0;
   endtask

   // Drive one cycle of inputs, predict, then compare after the edge.
   task automatic cycle(input string tag, input logic i_ena, input logic i_load,
                        input logic i_start, input logic i_stop,
                        input logic [15:0] i_fw, input logic [7:0] i_len);
      logic [15:0] nacc;
      exp_t e, g;
      ena = i_ena; load = i_load; start = i_start; stop = i_stop;
      freq_word = i_fw; burst_len = i_len;
      if (i_ena) begin
         if (i_stop) begin
            m_state = 0; m_acc = '0; m_f = 1'b0;
         end else begin
            case (m_state)
               0: if (i_start) begin
                  m_state = 1; m_acc = '0; m_f = 1'b0; m_cnt = '0; m_len = i_len;
               end
               1: begin
                  nacc = m_acc + m_fword;
                  if (m_f && !nacc[15]) begin
                     if (m_len != 0 && int'(m_cnt) + 1 == int'(m_len)) m_state = 2;
                     if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                  end
                  m_acc = nacc;
                  m_f = nacc[15];
               end
               default: m_state = 0;
            endcase
         end
         if (i_load) m_fword = i_fw;
      end
      e.f = m_f; e.busy = (m_state == 1); e.done = (m_state == 2) && i_ena;
      if (!i_ena) e.done = done;  // frozen: done holds its current value
      e.cnt = m_cnt;
      exp_q.push_back(e);
      @(posedge clk); #1;
      g = exp_q.pop_front();
      checks++;
      if ({f_out, busy, done, period_cnt} !== g) begin
         errors++;
         $display("FAIL %s t=%0t got f=%b busy=%b done=%b cnt=%0d exp f=%b busy=%b done=%b cnt=%0d",
                  tag, $time, f_out, busy, done, period_cnt, g.f, g.busy, g.done, g.cnt);
      end
   endtask

   task automatic idle_cycle(input string tag);
      cycle(tag, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      checks++;
      if ({f_out, busy, done, period_cnt} !== 11'b0) begin
         errors++;
         $display("FAIL reset_state got f=%b busy=%b done=%b cnt=%0d exp all 0",
                  f_out, busy, done, period_cnt);
      end
      rst_n = 1'b1;
      idle_cycle("reset_idle");
   endtask

   task automatic test_burst();
      int done_at = -1;
      cycle("burst_load", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd0);
      cycle("burst_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd3);
      for (int i = 1; i <= 16; i++) begin
         idle_cycle("burst_run");
         if (done && done_at < 0) done_at = i;
      end
      checks++;
      if (done_at != 12) begin
         errors++;
         $display("FAIL burst_done_time got %0d exp 12", done_at);
      end
      checks++;
      if (period_cnt !== 8'd3) begin
         errors++;
         $display("FAIL burst_period_cnt got %0d exp 3", period_cnt);
      end
   endtask

   task automatic test_continuous();
      int falls = 0, dones = 0;
      logic prev;
      cycle("cont_load", 1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, 8'd0);
      cycle("cont_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
      prev = f_out;
      for (int i = 0; i < 1000; i++) begin
         idle_cycle("cont_run");
         if (prev && !f_out) falls++;
         if (done) dones++;
         prev = f_out;
      end
      checks++;
      if (falls != 62 || dones != 0) begin
         errors++;
         $display("FAIL cont_periods got falls=%0d dones=%0d exp falls=62 dones=0", falls, dones);
      end
      cycle("cont_stop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 8'd0);
      checks++;
      if (busy !== 1'b0 || f_out !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL cont_stop got busy=%b f=%b done=%b exp 0 0 0", busy, f_out, done);
      end
      repeat (3) idle_cycle("cont_after_stop");
   endtask

   task automatic test_retune();
      int fall_t[$];
      logic prev;
      cycle("retune_load", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd0);
      cycle("retune_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
      idle_cycle("retune_run");
      idle_cycle("retune_run");
      prev = f_out;
      cycle("retune_newword", 1'b1, 1'b1, 1'b0, 1'b0, 16'h2000, 8'd0);
      for (int i = 4; i <= 30; i++) begin
         idle_cycle("retune_run");
         if (prev && !f_out) fall_t.push_back(i);
         prev = f_out;
      end
      checks++;
      if (fall_t.size() < 3 || fall_t[0] != 5 || fall_t[1] - fall_t[0] != 8 ||
          fall_t[2] - fall_t[1] != 8) begin
         errors++;
         $display("FAIL retune_period got n=%0d first=%0d exp first=5 spacing 8",
                  fall_t.size(), (fall_t.size() > 0) ? fall_t[0] : -1);
      end
      cycle("retune_stop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 8'd0);
   endtask

   task automatic test_priority();
      cycle("prio_start_stop", 1'b1, 1'b1, 1'b1, 1'b1, 16'h4000, 8'd0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL prio_idle got busy=%b exp 0", busy);
      end
      cycle("prio_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
      repeat (5) idle_cycle("prio_run");
      cycle("prio_restart", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd2);
      repeat (5) idle_cycle("prio_run2");
      checks++;
      if (period_cnt !== 8'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL prio_no_restart got cnt=%0d busy=%b exp cnt=2 busy=1", period_cnt, busy);
      end
      cycle("prio_stop", 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 8'd0);
   endtask

   task automatic test_ena();
      int done_at = -1;
      cycle("ena_load", 1'b1, 1'b1, 1'b0, 1'b0, 16'h4000, 8'd0);
      cycle("ena_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd3);
      for (int i = 1; i <= 22; i++) begin
         if (i >= 3 && i <= 7) cycle("ena_frozen", 1'b0, 1'b1, 1'b1, 1'b1, 16'h1111, 8'd9);
         else idle_cycle("ena_run");
         if (done && done_at < 0) done_at = i;
      end
      checks++;
      if (done_at != 17) begin
         errors++;
         $display("FAIL ena_done_time got %0d exp 17", done_at);
      end
   endtask

   task automatic test_back_to_back();
      cycle("b2b_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd1);
      while (!done && checks < 20000) idle_cycle("b2b_wait");
      cycle("b2b_start_in_done", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd1);
      cycle("b2b_restart", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd1);
      repeat (6) idle_cycle("b2b_run");
   endtask

   task automatic test_async_reset();
      cycle("ar_start", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 8'd0);
      repeat (6) idle_cycle("ar_run");
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if ({f_out, busy, done, period_cnt} !== 11'b0) begin
         errors++;
         $display("FAIL async_reset got f=%b busy=%b done=%b cnt=%0d exp all 0",
                  f_out, busy, done, period_cnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycle("ar_after");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         cycle("random", ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 49) == 0),
               16'($urandom_range(0, 65535) >> $urandom_range(0, 4)),
               8'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_burst();
      test_continuous();
      test_retune();
      test_priority();
      test_ena();
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
